// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arbiter_pkg;

  localparam int AW_DEF         = 16;
  localparam int DW_DEF         = 16;
  localparam int ADDR_LIMIT_DEF = 4096;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - combinational winner selection for mem_arbiter
// MEMARB_RR_EN: ties go to the port that did not win last (round-robin); otherwise port 0 wins.
import mem_arbiter_pkg::*;

module mem_arbiter_pick (
  input  logic [1:0] req,
  input  logic       owner,
  input  logic       last,
  input  logic       lock_q,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    // A held lock only keeps ownership while the owner is still asking.
    if (lock_q && req[owner]) begin
      grant = owner;
    end else if (req == 2'b11) begin
`ifdef MEMARB_RR_EN
      grant = ~last;
`else
      grant = PORT_CPU;
`endif
    end else if (req[1]) begin
      grant = PORT_DMA;
    end
  end

`ifndef MEMARB_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one async-read word memory between CPU (port 0) and loader/DMA (port 1)
// Build option MEMARB_RR_EN selects round-robin tie breaking inside mem_arbiter_pick.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          owner,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] LIMIT = (AW+1)'(ADDR_LIMIT);

  state_t        state;
  logic          lock_q;
  logic          last_q;
  logic          grant_valid;
  logic          grant;
  logic          cur_we;
  logic          cur_lock;
  logic          in_range;
  logic [1:0]    req_vec;

  assign req_vec   = {req1, req0};
  assign mem_addr  = owner ? addr1 : addr0;
  assign mem_wdata = owner ? wdata1 : wdata0;
  assign cur_we    = owner ? we1 : we0;
  assign cur_lock  = owner ? lock1 : lock0;
  assign in_range  = {1'b0, mem_addr} < LIMIT;
  assign busy      = (state != IDLE);
  // Gated by reset so an access interrupted by reset never commits its write.
  assign mem_rw    = (state == ACCESS) && cur_we && in_range && !reset;

  mem_arbiter_pick u_pick (
    .req    (req_vec),
    .owner  (owner),
    .last   (last_q),
    .lock_q (lock_q),
    .valid  (grant_valid),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      owner  <= PORT_CPU;
      lock_q <= 1'b0;
      last_q <= PORT_DMA;
    end else begin
      case (state)
        IDLE: begin
          if (lock_q && !req_vec[owner]) lock_q <= 1'b0;
          if (grant_valid) begin
            owner  <= grant;
            last_q <= grant;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          rdata  <= in_range ? mem_rdata : '0;
          ack0   <= (owner == PORT_CPU);
          ack1   <= (owner == PORT_DMA);
          err    <= !in_range;
          lock_q <= cur_lock;
          state  <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The granted requester must hold its request and payload from grant through access.
  a_payload_stable: assert property (@(posedge clk) disable iff (reset)
    (state == ACCESS) |->
      (owner ? ($past(req1) && req1 && $past(we1) == we1 && $past(addr1) == addr1 && $past(wdata1) == wdata1)
             : ($past(req0) && req0 && $past(we0) == we0 && $past(addr0) == addr0 && $past(wdata0) == wdata0)));

  a_ack_onehot: assert property (@(posedge clk) !(ack0 && ack1));

endmodule
